radiant_thresh_servo: RTL

//  Closed-loop trigger threshold servo for the 24 RADIANT trigger channels.

---
 rtl/radiant_thresh_servo_if.sv | 23 ++
 rtl/radiant_thresh_servo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/radiant_thresh_servo_if.sv
// Threshold write bus between the servo (master) and the PWM threshold register port (slave).
interface radiant_thresh_servo_if #(
    parameter int THRESH_W = 16
) ();
    logic                thresh_wr_o;
    logic [4:0]          thresh_chan_o;
    logic [THRESH_W-1:0] thresh_dat_o;
    logic                thresh_ack_i;

    modport master (
        output thresh_wr_o,
        output thresh_chan_o,
        output thresh_dat_o,
        input  thresh_ack_i
    );

    modport slave (
        input  thresh_wr_o,
        input  thresh_chan_o,
        input  thresh_dat_o,
        output thresh_ack_i
    );
endinterface

// File: rtl/radiant_thresh_servo.sv
// Closed-loop trigger threshold servo: gate edge scalers, step thresholds toward a target rate, write changes out.
// Optional macro RADIANT_SERVO_TIMEOUT_EN: abandon a write after 256 un-acked cycles and set sticky err_o.
module radiant_thresh_servo #(
    parameter int                  NCHAN       = 24,
    parameter int                  THRESH_W    = 16,
    parameter int                  COUNT_W     = 16,
    parameter int                  STEP_W      = 8,
    parameter logic [THRESH_W-1:0] THRESH_INIT = 16'h8000
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   enable_i,
    input  logic [23:0]            period_i,
    input  logic [COUNT_W-1:0]     target_i,
    input  logic [COUNT_W-1:0]     deadband_i,
    input  logic [STEP_W-1:0]      step_i,
    input  logic [THRESH_W-1:0]    thresh_min_i,
    input  logic [THRESH_W-1:0]    thresh_max_i,
    input  logic [NCHAN-1:0]       chan_mask_i,
    input  logic [NCHAN-1:0]       trig_i,
    radiant_thresh_servo_if.master thr_if,
    input  logic [4:0]             scaler_sel_i,
    output logic [COUNT_W-1:0]     scaler_dat_o,
    output logic                   busy_o,
    output logic                   sweep_done_o,
    output logic                   err_o
);

    localparam int TW1 = THRESH_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_GATE, S_ADJUST, S_WRITE} state_t;

    state_t                    state_q, state_d;
    logic [NCHAN-1:0]          trig_q;
    logic [23:0]               gate_cnt_q, gate_cnt_d;
    logic [4:0]                ch_q, ch_d;
    logic [THRESH_W-1:0]       dat_q, dat_d;
    logic                      done_q, done_d;
    logic                      clear_live, latch_en, store_en, adv;
    logic [23:0]               period_eff;
    logic [NCHAN*COUNT_W-1:0]  latch_flat;
    logic [NCHAN*THRESH_W-1:0] thr_flat;

    logic [COUNT_W-1:0]        cur_cnt, cnt_hi, cnt_lo;
    logic [COUNT_W:0]          hi_sum;
    logic [THRESH_W-1:0]       cur_thr, up_thr, dn_thr, new_thr;
    logic [THRESH_W:0]         up_sum, dn_floor;

`ifdef RADIANT_SERVO_TIMEOUT_EN
    logic [7:0]                to_cnt_q, to_cnt_d;
    logic                      err_q, err_d;
`endif

    assign period_eff = (period_i == 24'd0) ? 24'd1 : period_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) trig_q <= '0;
        else          trig_q <= trig_i;
    end

    // Per-channel live scaler, latched scaler and stored threshold.
    genvar gi;
    generate
        for (gi = 0; gi < NCHAN; gi++) begin : g_chan
            logic [COUNT_W-1:0]  live_q, latch_q, live_inc;
            logic [THRESH_W-1:0] thr_q;
            logic                edge_w;

            assign edge_w   = trig_i[gi] & ~trig_q[gi];
            assign live_inc = (edge_w && (live_q != {COUNT_W{1'b1}})) ? live_q + COUNT_W'(1) : live_q;

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    live_q  <= '0;
                    latch_q <= '0;
                    thr_q   <= THRESH_INIT;
                end else begin
                    if (clear_live)
                        live_q <= '0;
                    else if (state_q == S_GATE)
                        live_q <= live_inc;
                    if (latch_en)
                        latch_q <= live_inc;
                    if (store_en && (ch_q == 5'(gi)))
                        thr_q <= new_thr;
                end
            end

            assign latch_flat[gi*COUNT_W +: COUNT_W]   = latch_q;
            assign thr_flat[gi*THRESH_W +: THRESH_W]   = thr_q;
        end
    endgenerate

    assign cur_cnt = latch_flat[int'(ch_q)*COUNT_W +: COUNT_W];
    assign cur_thr = thr_flat[int'(ch_q)*THRESH_W +: THRESH_W];

    // Band edges: upper saturates at all-ones, lower floors at zero.
    assign hi_sum = {1'b0, target_i} + {1'b0, deadband_i};
    assign cnt_hi = hi_sum[COUNT_W] ? {COUNT_W{1'b1}} : hi_sum[COUNT_W-1:0];
    assign cnt_lo = (target_i > deadband_i) ? (target_i - deadband_i) : '0;

    assign up_sum   = {1'b0, cur_thr} + TW1'(step_i);
    assign dn_floor = {1'b0, thresh_min_i} + TW1'(step_i);
    assign up_thr   = (up_sum > {1'b0, thresh_max_i}) ? thresh_max_i : up_sum[THRESH_W-1:0];
    assign dn_thr   = ({1'b0, cur_thr} < dn_floor) ? thresh_min_i : (cur_thr - THRESH_W'(step_i));

    always_comb begin
        new_thr = cur_thr;
        if (cur_cnt > cnt_hi)
            new_thr = (thresh_min_i > thresh_max_i) ? thresh_min_i : up_thr;
        else if (cur_cnt < cnt_lo)
            new_thr = (thresh_min_i > thresh_max_i) ? thresh_min_i : dn_thr;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            gate_cnt_q <= '0;
            ch_q       <= '0;
            dat_q      <= '0;
            done_q     <= 1'b0;
`ifdef RADIANT_SERVO_TIMEOUT_EN
            to_cnt_q   <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            ch_q       <= ch_d;
            dat_q      <= dat_d;
            done_q     <= done_d;
`ifdef RADIANT_SERVO_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        ch_d       = ch_q;
        dat_d      = dat_q;
        done_d     = 1'b0;
        clear_live = 1'b0;
        latch_en   = 1'b0;
        store_en   = 1'b0;
        adv        = 1'b0;
`ifdef RADIANT_SERVO_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    state_d    = S_GATE;
                    gate_cnt_d = period_eff;
                    clear_live = 1'b1;
                end
            end
            S_GATE: begin
                if (!enable_i) begin
                    state_d = S_IDLE;
                end else if (gate_cnt_q <= 24'd1) begin
                    latch_en = 1'b1;
                    ch_d     = '0;
                    state_d  = S_ADJUST;
                end else begin
                    gate_cnt_d = gate_cnt_q - 24'd1;
                end
            end
            S_ADJUST: begin
                if (!enable_i) begin
                    state_d = S_IDLE;
                end else if (chan_mask_i[ch_q] && (new_thr != cur_thr)) begin
                    store_en = 1'b1;
                    dat_d    = new_thr;
                    state_d  = S_WRITE;
`ifdef RADIANT_SERVO_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end else begin
                    adv = 1'b1;
                end
            end
            S_WRITE: begin
`ifdef RADIANT_SERVO_TIMEOUT_EN
                if (thr_if.thresh_ack_i || (to_cnt_q == 8'hFF)) begin
                    if (!thr_if.thresh_ack_i)
                        err_d = 1'b1;
                    if (enable_i) adv = 1'b1;
                    else          state_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
`else
                if (thr_if.thresh_ack_i) begin
                    if (enable_i) adv = 1'b1;
                    else          state_d = S_IDLE;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // A finished channel either moves on or closes the sweep and re-arms the gate.
        if (adv) begin
            if (ch_q == 5'(NCHAN-1)) begin
                done_d     = 1'b1;
                state_d    = S_GATE;
                gate_cnt_d = period_eff;
                clear_live = 1'b1;
            end else begin
                ch_d    = ch_q + 5'd1;
                state_d = S_ADJUST;
            end
        end
    end

    assign thr_if.thresh_wr_o   = (state_q == S_WRITE);
    assign thr_if.thresh_chan_o = ch_q;
    assign thr_if.thresh_dat_o  = dat_q;
    assign busy_o               = (state_q != S_IDLE);
    assign sweep_done_o         = done_q;
    assign scaler_dat_o         = (int'(scaler_sel_i) < NCHAN) ?
                                  latch_flat[int'(scaler_sel_i)*COUNT_W +: COUNT_W] : '0;
`ifdef RADIANT_SERVO_TIMEOUT_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
